// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// Latency: MULT_CYCLES / DIV_CYCLES after the accepting edge; MTHI/MTLO take effect at the accepting edge.
// Backpressure: Busy is high while an operation runs; Start is ignored while Busy is high, and Cancel kills a same-cycle Start.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        Start,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [4:0]    r_cnt;
    logic [2:0]    r_op;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic          w_accept;
    logic          w_long_op;
    logic          w_done;
    logic [4:0]    w_load_cnt;

    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_div_b;
    logic signed [31:0] w_quot_s;
    logic signed [31:0] w_rem_s;
    logic               w_div_ovf;
    logic               w_res_wr;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    // Command decode: a command only counts when idle, not cancelled, and MDOp is 1..6.
    always_comb begin
        w_accept   = 1'b0;
        w_long_op  = 1'b0;
        w_load_cnt = 5'd0;
        if (Start && !Cancel && (r_state == S_IDLE) && (MDOp != 3'd0) && (MDOp != 3'd7)) begin
            w_accept = 1'b1;
        end
        if (w_accept && (MDOp <= OP_DIVU)) begin
            w_long_op = 1'b1;
        end
        if ((MDOp == OP_MULT) || (MDOp == OP_MULTU)) begin
            w_load_cnt = 5'(MULT_CYCLES);
        end else begin
            w_load_cnt = 5'(DIV_CYCLES);
        end
        w_done = (r_state == S_RUN) && (r_cnt == 5'd1);
    end

    // Next-state logic: IDLE->RUN on a multi-cycle op, RUN->IDLE as the counter hits zero.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_long_op) w_state_nxt = S_RUN;
            S_RUN:   if (w_done)    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result computation from the latched operands only.  The divisor is forced
    // to 1 when zero so the divider never sees 0; that result is discarded anyway.
    always_comb begin
        w_prod_s  = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
        w_prod_u  = {32'd0, r_a} * {32'd0, r_b};
        w_div_b   = (r_b == 32'd0) ? 32'd1 : r_b;
        w_div_ovf = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
        if (w_div_ovf) begin
            w_quot_s = 32'sh8000_0000;
            w_rem_s  = 32'sd0;
        end else begin
            w_quot_s = $signed(r_a) / $signed(w_div_b);
            w_rem_s  = $signed(r_a) % $signed(w_div_b);
        end

        w_res_wr = 1'b0;
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            OP_MULT: begin
                w_res_wr = 1'b1;
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            OP_MULTU: begin
                w_res_wr = 1'b1;
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            OP_DIV: begin
                w_res_wr = (r_b != 32'd0);
                w_res_hi = w_rem_s;
                w_res_lo = w_quot_s;
            end
            OP_DIVU: begin
                w_res_wr = (r_b != 32'd0);
                w_res_hi = r_a % w_div_b;
                w_res_lo = r_a / w_div_b;
            end
            default: begin
                w_res_wr = 1'b0;
            end
        endcase
    end

    // Datapath: operand/op latch, countdown, and HI/LO updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 5'd0;
            r_op  <= 3'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - 5'd1;
            if (w_done && w_res_wr) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (w_long_op) begin
            r_cnt <= w_load_cnt;
            r_op  <= MDOp;
            r_a   <= A;
            r_b   <= B;
        end else if (w_accept && (MDOp == OP_MTHI)) begin
            r_hi <= A;
        end else if (w_accept && (MDOp == OP_MTLO)) begin
            r_lo <= A;
        end
    end

    assign Busy = (r_state == S_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios plus random traffic against an arithmetic reference model.
// Outputs are sampled 1 time unit after each rising edge.
// Every wait on Busy is bounded by a cycle budget.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  MDOp;
    logic        Start, Cancel;
    logic        Busy;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_left;
    bit          m_pend_wr;
    logic [31:0] m_pend_hi, m_pend_lo;
    logic [31:0] m_hi, m_lo;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp),
        .Start(Start), .Cancel(Cancel), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result of a multi-cycle op, computed with 64-bit integer arithmetic.
    function automatic void ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output bit wr, output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, mag_a, mag_b, q, r;
        logic [63:0] p;
        wr = 1'b1; hi = m_hi; lo = m_lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'd3: begin
                if (b == 0) wr = 1'b0;
                else begin
                    mag_a = (sa < 0) ? -sa : sa;
                    mag_b = (sb < 0) ? -sb : sb;
                    q = mag_a / mag_b;
                    r = mag_a % mag_b;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    p = 64'(q); lo = p[31:0];
                    p = 64'(r); hi = p[31:0];
                end
            end
            3'd4: begin
                if (b == 0) wr = 1'b0;
                else begin lo = a / b; hi = a % b; end
            end
            default: wr = 1'b0;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs presented before that edge.
    task automatic model_edge();
        if (reset) begin
            m_left = 0; m_pend_wr = 0; m_hi = 0; m_lo = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pend_wr) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
        end else if (Start && !Cancel && MDOp >= 3'd1 && MDOp <= 3'd6) begin
            if (MDOp == 3'd5) m_hi = A;
            else if (MDOp == 3'd6) m_lo = A;
            else begin
                ref_result(MDOp, A, B, m_pend_wr, m_pend_hi, m_pend_lo);
                m_left = (MDOp <= 3'd2) ? MC : DC;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare all outputs to the model.
    task automatic cyc(input bit rst, input bit st, input bit cn, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
        reset = rst; Start = st; Cancel = cn; MDOp = op; A = a; B = b;
        @(posedge clk);
        model_edge();
        #1;
        check_eq("busy", {63'd0, Busy}, {63'd0, m_left > 0});
        check_eq("hi", {32'd0, HI}, {32'd0, m_hi});
        check_eq("lo", {32'd0, LO}, {32'd0, m_lo});
    endtask

    task automatic idle();
        cyc(0, 0, 0, 3'd0, $urandom, $urandom);
    endtask

    // Issue an op and measure how many sampled cycles Busy stays high.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_len);
        int n = 0;
        int guard = 0;
        cyc(0, 1, 0, op, a, b);
        while (Busy && guard < 64) begin
            n++; guard++;
            idle();
        end
        check_eq({tag, "_busy_len"}, 64'(n), 64'(exp_len));
    endtask

    initial begin
        int n;
        bit st, cn, rst;
        logic [31:0] ra, rb;
        m_left = 0; m_pend_wr = 0; m_hi = 0; m_lo = 0; m_pend_hi = 0; m_pend_lo = 0;
        reset = 1; Start = 0; Cancel = 0; MDOp = 0; A = 0; B = 0;

        // Reset state
        cyc(1, 0, 0, 3'd0, 0, 0);
        cyc(1, 0, 0, 3'd0, 0, 0);
        check_eq("rst_busy", {63'd0, Busy}, 64'd0);
        check_eq("rst_hi", {32'd0, HI}, 64'd0);
        check_eq("rst_lo", {32'd0, LO}, 64'd0);

        // MULT / MULTU
        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'h3, MC);
        check_eq("mult_hi", {32'd0, HI}, 64'hFFFF_FFFF);
        check_eq("mult_lo", {32'd0, LO}, 64'hFFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'h3, MC);
        check_eq("multu_hi", {32'd0, HI}, 64'h2);
        check_eq("multu_lo", {32'd0, LO}, 64'hFFFF_FFFA);

        // DIV signed, negative dividend
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'h2, DC);
        check_eq("div_lo", {32'd0, LO}, 64'hFFFF_FFFD);
        check_eq("div_hi", {32'd0, HI}, 64'hFFFF_FFFF);

        // DIV overflow corner
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC);
        check_eq("div_ovf_lo", {32'd0, LO}, 64'h8000_0000);
        check_eq("div_ovf_hi", {32'd0, HI}, 64'h0);

        // MTHI/MTLO then DIVU by zero leaves them intact
        cyc(0, 1, 0, 3'd5, 32'h1234, 0);
        check_eq("mthi_busy", {63'd0, Busy}, 64'd0);
        cyc(0, 1, 0, 3'd6, 32'h5678, 0);
        check_eq("mtlo_hi_kept", {32'd0, HI}, 64'h1234);
        run_op("divu0", 3'd4, 32'hDEAD, 32'h0, DC);
        check_eq("divu0_hi", {32'd0, HI}, 64'h1234);
        check_eq("divu0_lo", {32'd0, LO}, 64'h5678);

        // MULT issued while DIV runs is ignored
        cyc(0, 1, 0, 3'd3, 32'd100, 32'd7);
        n = 0;
        for (int k = 0; k < 40 && Busy; k++) begin
            n++;
            if (k == 3) cyc(0, 1, 0, 3'd1, 32'hFFFF, 32'hFFFF);
            else idle();
        end
        check_eq("stall_busy_len", 64'(n), 64'(DC));
        check_eq("stall_lo", {32'd0, LO}, 64'd14);
        check_eq("stall_hi", {32'd0, HI}, 64'd2);

        // Reset in the middle of a MULT discards the result
        cyc(0, 1, 0, 3'd1, 32'h7, 32'h9);
        idle();
        cyc(1, 0, 0, 3'd0, 0, 0);
        check_eq("midrst_busy", {63'd0, Busy}, 64'd0);
        check_eq("midrst_hi", {32'd0, HI}, 64'd0);
        check_eq("midrst_lo", {32'd0, LO}, 64'd0);
        for (int k = 0; k < MC + 2; k++) idle();
        check_eq("midrst_lo_late", {32'd0, LO}, 64'd0);

        // Reset wins over a simultaneous Start
        cyc(1, 1, 0, 3'd5, 32'hAAAA, 0);
        check_eq("rst_prio_hi", {32'd0, HI}, 64'd0);

        // Cancelled Starts do nothing
        cyc(0, 1, 0, 3'd5, 32'hAAAA, 0);
        cyc(0, 1, 1, 3'd1, 32'h7, 32'h9);
        check_eq("cancel_busy", {63'd0, Busy}, 64'd0);
        cyc(0, 1, 1, 3'd6, 32'hBBBB, 0);
        check_eq("cancel_lo", {32'd0, LO}, 64'd0);
        check_eq("cancel_hi", {32'd0, HI}, 64'hAAAA);

        // Reserved / NONE ops are no-ops
        cyc(0, 1, 0, 3'd7, 32'h1, 32'h1);
        check_eq("rsvd_busy", {63'd0, Busy}, 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            st  = ($urandom_range(0, 99) < 35);
            cn  = ($urandom_range(0, 99) < 10);
            rst = ($urandom_range(0, 999) < 8);
            case ($urandom_range(0, 3))
                0: ra = $urandom_range(0, 20);
                1: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            cyc(rst, st, cn, 3'($urandom_range(0, 7)), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
